// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use, flow-change flush, memory wait with timeout, halt.
// Optional SINGLE_STEP_EN adds a step input that releases HALT for one cycle per rising edge.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic        flow_change_ID_EX,
  input  logic        hlt_ID_EX,
  input  logic        ld_ID_EX,
  input  logic [3:0]  dst_addr_ID_EX,
  input  logic [3:0]  src0_addr_IM_ID,
  input  logic [3:0]  src1_addr_IM_ID,
  input  logic        src0_used,
  input  logic        src1_used,
  input  logic        mem_req_EX_DM,
  input  logic        mem_rdy,
  output logic        stall_IM_ID,
  output logic        stall_ID_EX,
  output logic        stall_EX_DM,
  output logic        flush_IM_ID,
  output logic        flush_ID_EX,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MWAIT, HALT} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           mem_err_q, mem_err_d;
  logic [15:0]    stall_cnt_q, stall_cnt_d;
  logic           load_use, mem_stall_run, tmo_hit, step_go;
  logic           st_im, st_ie, st_ed, fl_im, fl_ie, hl;

  assign load_use = ld_ID_EX && (dst_addr_ID_EX != 4'd0) &&
                    ((src0_used && (src0_addr_IM_ID == dst_addr_ID_EX)) ||
                     (src1_used && (src1_addr_IM_ID == dst_addr_ID_EX)));
  assign mem_stall_run = mem_req_EX_DM && !mem_rdy;
  assign tmo_hit       = (tmo_q == TW'(MEM_TIMEOUT - 1));

`ifdef SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
  assign step_go = step && !step_q && !mem_err_q;
`else
  assign step_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall_run) begin
          state_d = MWAIT;
          tmo_d   = '0;
        end else if (hlt_ID_EX) begin
          state_d = HALT;
        end
      end
      // mem_rdy wins over a timeout landing in the same cycle
      MWAIT: begin
        if (mem_rdy) begin
          state_d = hlt_ID_EX ? HALT : RUN;
        end else if (tmo_hit) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    st_im = 1'b0;
    st_ie = 1'b0;
    st_ed = 1'b0;
    fl_im = 1'b0;
    fl_ie = 1'b0;
    hl    = 1'b0;
    unique case (state_q)
      RUN, MWAIT: begin
        if ((state_q == RUN && mem_stall_run) || (state_q == MWAIT && !mem_rdy)) begin
          st_im = 1'b1;
          st_ie = 1'b1;
          st_ed = 1'b1;
        end else if (flow_change_ID_EX) begin
          fl_im = 1'b1;
          fl_ie = 1'b1;
        end else if (load_use) begin
          st_im = 1'b1;
          fl_ie = 1'b1;
        end
      end
      HALT: begin
        if (!step_go) begin
          st_im = 1'b1;
          st_ie = 1'b1;
          st_ed = 1'b1;
          hl    = 1'b1;
        end
      end
      default: ;
    endcase
    // outputs are combinational, so gate them explicitly while reset is held
    if (!rst_n) begin
      st_im = 1'b0;
      st_ie = 1'b0;
      st_ed = 1'b0;
      fl_im = 1'b0;
      fl_ie = 1'b0;
      hl    = 1'b0;
    end
  end

  assign stall_cnt_d = (st_im && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  assign stall_IM_ID = st_im;
  assign stall_ID_EX = st_ie;
  assign stall_EX_DM = st_ed;
  assign flush_IM_ID = fl_im;
  assign flush_ID_EX = fl_ie;
  assign halted      = hl;
  assign mem_err     = mem_err_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expectations queued at drive time, popped at sample time.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic        flow_change_ID_EX, hlt_ID_EX, ld_ID_EX;
  logic [3:0]  dst_addr_ID_EX, src0_addr_IM_ID, src1_addr_IM_ID;
  logic        src0_used, src1_used, mem_req_EX_DM, mem_rdy;
  logic        stall_IM_ID, stall_ID_EX, stall_EX_DM, flush_IM_ID, flush_ID_EX;
  logic        halted, mem_err;
  logic [15:0] stall_cnt;

  int tests_run = 0;
  int fails = 0;
  logic [15:0] exp_cnt = 16'd0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [1:0] fl;
    logic       h;
    logic       me;
  } exp_t;
  exp_t sb[$];

  pipe_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .flow_change_ID_EX(flow_change_ID_EX), .hlt_ID_EX(hlt_ID_EX), .ld_ID_EX(ld_ID_EX),
    .dst_addr_ID_EX(dst_addr_ID_EX), .src0_addr_IM_ID(src0_addr_IM_ID),
    .src1_addr_IM_ID(src1_addr_IM_ID), .src0_used(src0_used), .src1_used(src1_used),
    .mem_req_EX_DM(mem_req_EX_DM), .mem_rdy(mem_rdy),
    .stall_IM_ID(stall_IM_ID), .stall_ID_EX(stall_ID_EX), .stall_EX_DM(stall_EX_DM),
    .flush_IM_ID(flush_IM_ID), .flush_ID_EX(flush_ID_EX), .halted(halted),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    flow_change_ID_EX = 1'b0; hlt_ID_EX = 1'b0; ld_ID_EX = 1'b0;
    dst_addr_ID_EX = 4'd0; src0_addr_IM_ID = 4'd0; src1_addr_IM_ID = 4'd0;
    src0_used = 1'b0; src1_used = 1'b0; mem_req_EX_DM = 1'b0; mem_rdy = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [1:0] fl,
                     input logic h, input logic me);
    exp_t e, g;
    e.tag = tag; e.st = st; e.fl = fl; e.h = h; e.me = me;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    tests_run++;
    assert ({stall_IM_ID, stall_ID_EX, stall_EX_DM} === g.st) else begin
      fails++;
      $error("FAIL %s stalls got %b exp %b", g.tag, {stall_IM_ID, stall_ID_EX, stall_EX_DM}, g.st);
    end
    tests_run++;
    assert ({flush_IM_ID, flush_ID_EX} === g.fl) else begin
      fails++;
      $error("FAIL %s flushes got %b exp %b", g.tag, {flush_IM_ID, flush_ID_EX}, g.fl);
    end
    tests_run++;
    assert (halted === g.h) else begin
      fails++;
      $error("FAIL %s halted got %b exp %b", g.tag, halted, g.h);
    end
    tests_run++;
    assert (mem_err === g.me) else begin
      fails++;
      $error("FAIL %s mem_err got %b exp %b", g.tag, mem_err, g.me);
    end
    tests_run++;
    assert (stall_cnt === exp_cnt) else begin
      fails++;
      $error("FAIL %s stall_cnt got %0d exp %0d", g.tag, stall_cnt, exp_cnt);
    end
    if (g.st[2] && rst_n && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    step = 1'b0;
    rst_n = 1'b0;
    idle();
    // hazard inputs present during reset must not leak to outputs
    @(negedge clk);
    ld_ID_EX = 1'b1; dst_addr_ID_EX = 4'd3; src0_addr_IM_ID = 4'd3; src0_used = 1'b1;
    chk("in_reset", 3'b000, 2'b00, 1'b0, 1'b0);

    @(negedge clk); rst_n = 1'b1; idle();
    chk("idle", 3'b000, 2'b00, 1'b0, 1'b0);

    @(negedge clk);
    ld_ID_EX = 1'b1; dst_addr_ID_EX = 4'd3; src0_addr_IM_ID = 4'd3; src0_used = 1'b1;
    chk("load_use", 3'b100, 2'b01, 1'b0, 1'b0);
    @(negedge clk); idle();
    chk("after_load_use", 3'b000, 2'b00, 1'b0, 1'b0);

    @(negedge clk);
    ld_ID_EX = 1'b1; dst_addr_ID_EX = 4'd3; src0_addr_IM_ID = 4'd3; src0_used = 1'b1;
    flow_change_ID_EX = 1'b1;
    chk("flow_over_lu", 3'b000, 2'b11, 1'b0, 1'b0);

    @(negedge clk); idle();
    ld_ID_EX = 1'b1; src0_used = 1'b1;
    chk("dst_zero", 3'b000, 2'b00, 1'b0, 1'b0);

    @(negedge clk); idle();
    ld_ID_EX = 1'b1; dst_addr_ID_EX = 4'd9; src1_addr_IM_ID = 4'd9; src1_used = 1'b1;
    src0_addr_IM_ID = 4'd2; src0_used = 1'b1;
    chk("lu_src1", 3'b100, 2'b01, 1'b0, 1'b0);

    @(negedge clk); idle();
    ld_ID_EX = 1'b1; dst_addr_ID_EX = 4'd7; src0_addr_IM_ID = 4'd7; src1_addr_IM_ID = 4'd7;
    chk("lu_unused", 3'b000, 2'b00, 1'b0, 1'b0);

    // memory stall: mem_rdy low 5 cycles, flow change arriving meanwhile is held
    @(negedge clk); idle(); mem_req_EX_DM = 1'b1;
    chk("mem_run", 3'b111, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); flow_change_ID_EX = (i == 2);
      chk("mem_wait", 3'b111, 2'b00, 1'b0, 1'b0);
    end
    @(negedge clk); flow_change_ID_EX = 1'b0; mem_rdy = 1'b1;
    chk("mem_release", 3'b000, 2'b00, 1'b0, 1'b0);
    @(negedge clk); idle();
    chk("mem_after", 3'b000, 2'b00, 1'b0, 1'b0);

    // mem_rdy on the last allowed MWAIT cycle beats the timeout
    @(negedge clk); mem_req_EX_DM = 1'b1;
    chk("rdy_win_run", 3'b111, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("rdy_win_wait", 3'b111, 2'b00, 1'b0, 1'b0);
    end
    @(negedge clk); mem_rdy = 1'b1;
    chk("rdy_win_rel", 3'b000, 2'b00, 1'b0, 1'b0);
    @(negedge clk); idle();
    chk("rdy_win_after", 3'b000, 2'b00, 1'b0, 1'b0);

    // halt with a simultaneous flow change still flushes
    @(negedge clk); hlt_ID_EX = 1'b1; flow_change_ID_EX = 1'b1;
    chk("hlt_cycle", 3'b000, 2'b11, 1'b0, 1'b0);
    @(negedge clk); idle();
    chk("halted", 3'b111, 2'b00, 1'b1, 1'b0);
    @(negedge clk); flow_change_ID_EX = 1'b1;
    chk("halted_hold", 3'b111, 2'b00, 1'b1, 1'b0);
    @(negedge clk); idle();
`ifdef SINGLE_STEP_EN
    step = 1'b1;
    chk("step1", 3'b000, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("step1_back", 3'b111, 2'b00, 1'b1, 1'b0);
    @(negedge clk); step = 1'b0;
    chk("step_low", 3'b111, 2'b00, 1'b1, 1'b0);
    @(negedge clk); step = 1'b1;
    chk("step2", 3'b000, 2'b00, 1'b0, 1'b0);
    @(negedge clk); step = 1'b0;
    chk("step2_back", 3'b111, 2'b00, 1'b1, 1'b0);
`else
    chk("halted_stay", 3'b111, 2'b00, 1'b1, 1'b0);
`endif

    @(negedge clk); rst_n = 1'b0; exp_cnt = 16'd0;
    chk("rst_pulse1", 3'b000, 2'b00, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_rel1", 3'b000, 2'b00, 1'b0, 1'b0);

    // timeout: RUN stall + 16 MWAIT cycles, then HALT with mem_err
    @(negedge clk); mem_req_EX_DM = 1'b1;
    chk("tmo_run", 3'b111, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tmo_wait", 3'b111, 2'b00, 1'b0, 1'b0);
    end
    @(negedge clk); idle();
    chk("tmo_halt", 3'b111, 2'b00, 1'b1, 1'b1);
`ifdef SINGLE_STEP_EN
    @(negedge clk); step = 1'b1;
    chk("step_ignored", 3'b111, 2'b00, 1'b1, 1'b1);
    @(negedge clk); step = 1'b0;
`else
    @(negedge clk);
`endif
    chk("tmo_halt2", 3'b111, 2'b00, 1'b1, 1'b1);

    // stall_cnt saturates while parked in HALT
    for (int i = 0; i < 65600; i++) @(negedge clk);
    exp_cnt = 16'hFFFF;
    chk("cnt_sat", 3'b111, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    chk("cnt_hold", 3'b111, 2'b00, 1'b1, 1'b1);

    @(negedge clk); rst_n = 1'b0; exp_cnt = 16'd0;
    chk("rst_pulse2", 3'b000, 2'b00, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    ld_ID_EX = 1'b1; dst_addr_ID_EX = 4'd5; src1_addr_IM_ID = 4'd5; src1_used = 1'b1;
    chk("first_after_rst", 3'b100, 2'b01, 1'b0, 1'b0);
    @(negedge clk); idle();
    chk("final_idle", 3'b000, 2'b00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of consecutive MWAIT cycles before a memory error.
REQ-002 The block SHALL have port clk, input, 1, system clock.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port flow_change_ID_EX, input, 1, jump or taken branch resolved in EX.
REQ-005 The block SHALL have port hlt_ID_EX, input, 1, halt instruction is in EX.
REQ-006 The block SHALL have port ld_ID_EX, input, 1, instruction in EX is a load.
REQ-007 The block SHALL have port dst_addr_ID_EX, input, 4, destination register of the EX instruction.
REQ-008 The block SHALL have ports src0_addr_IM_ID and src1_addr_IM_ID, input, 4 each, source registers of the ID instruction.
REQ-009 The block SHALL have ports src0_used and src1_used, input, 1 each, which qualify the corresponding source register.
REQ-010 The block SHALL have ports mem_req_EX_DM, input, 1, a data-memory access is in DM; and mem_rdy, input, 1, memory completes this cycle.
REQ-011 The block SHALL have ports stall_IM_ID, stall_ID_EX and stall_EX_DM, output, 1 each, which hold the PC and each pipe register.
REQ-012 The block SHALL have ports flush_IM_ID and flush_ID_EX, output, 1 each, which load a NOP into the named register.
REQ-013 The block SHALL have ports halted, output, 1, FSM is in HALT; mem_err, output, 1, sticky memory timeout.
REQ-014 The block SHALL have port stall_cnt, output, 16, saturating count of cycles in which stall_IM_ID is high.

Function
REQ-015 The block SHALL implement an FSM with states RUN, MWAIT and HALT.
REQ-016 All stall and flush outputs SHALL be combinational from state and inputs, taking effect in the same cycle.
REQ-017 Priority SHALL be: HALT > memory stall > flow change > load-use.
REQ-018 In RUN, the load-use condition SHALL be: ld_ID_EX, dst_addr_ID_EX != 0, and a match with any used source register.
REQ-019 On load-use, the block SHALL assert stall_IM_ID and flush_ID_EX for exactly one cycle, with no state change.
REQ-020 In RUN, when flow_change_ID_EX is high, the block SHALL assert flush_IM_ID and flush_ID_EX, keep stall_IM_ID low so the PC loads the target, and suppress load-use for that cycle.
REQ-021 In RUN, when mem_req_EX_DM is high and mem_rdy is low, the block SHALL assert all three stalls, assert no flush, and move to MWAIT next cycle.
REQ-022 In MWAIT, the block SHALL assert all three stalls and no flush; a flow change arriving in this period is held in ID_EX and evaluated after release.
REQ-023 In MWAIT, when mem_rdy is high, the block SHALL deassert stalls in that cycle and return to RUN.
REQ-024 A timeout counter SHALL clear on entry to MWAIT and increment each MWAIT cycle.
REQ-025 When the timeout counter reaches MEM_TIMEOUT-1 with mem_rdy low, the block SHALL set mem_err and move to HALT; mem_rdy in that same cycle SHALL win.
REQ-026 In RUN, when hlt_ID_EX is high and no memory stall is active, the block SHALL move to HALT next cycle; flushes requested in that cycle SHALL still be asserted.
REQ-027 In HALT, the block SHALL assert all stalls and halted, and assert no flush.
REQ-028 stall_cnt SHALL hold at 16'hFFFF once it reaches that value.

Reset
REQ-029 On rst_n low, at any time including during MWAIT, the block SHALL immediately enter RUN and clear the timeout counter, stall_cnt and mem_err.
REQ-030 During reset, all stall and flush outputs and halted SHALL be 0.
REQ-031 The first clock after reset release SHALL evaluate normally.

Configuration
REQ-032 When SINGLE_STEP_EN is defined, the block SHALL add input step (1 bit) and register it for rising-edge detection.
REQ-033 With SINGLE_STEP_EN defined, a step rising edge in HALT with mem_err low SHALL drop all stalls and halted for exactly one cycle, then return to HALT.
REQ-034 With SINGLE_STEP_EN defined, a step rising edge SHALL be ignored when mem_err is set.
REQ-035 When SINGLE_STEP_EN is undefined, the step port SHALL be absent and HALT SHALL be left only by reset.

Verification
REQ-036 Stimulus: ld_ID_EX=1, dst=3, src0=3, src0_used=1 -> required response: stall_IM_ID=1 and flush_ID_EX=1 for one cycle, then 0; stall_cnt=1.
REQ-037 Stimulus: same load-use plus flow_change_ID_EX=1 -> required response: flush_IM_ID=1, flush_ID_EX=1, stall_IM_ID=0.
REQ-038 Stimulus: dst=0 matching src0=0 with ld_ID_EX=1 -> required response: no stall.
REQ-039 Stimulus: mem_req=1 with mem_rdy low for 5 cycles -> required response: all stalls high for 5 cycles, then released in the mem_rdy cycle; mem_err=0.
REQ-040 Stimulus: mem_rdy never asserted, MEM_TIMEOUT=16 -> required response: mem_err=1 and halted=1 after 16 MWAIT cycles; rst_n pulse clears both.
REQ-041 Stimulus: hlt_ID_EX pulse -> required response: halted=1 next cycle and stalls held; with SINGLE_STEP_EN, each step edge gives exactly one unstalled cycle.
